// File: rtl/ls_unit.sv
// Load/store unit between the multicycle datapath and word-organised memory.
// Byte/half/word loads are lane-selected and extended; sub-word stores use a
// read-modify-write of the containing word; misaligned requests are rejected.
module ls_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wlo_q, wlo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        req_mis;
  logic [1:0]  lane;
  logic [4:0]  bsh, hsh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val, merge_val;

  // Lane selection, load extension and store merge from the captured word.
  // Big-endian swaps the lane index; the half lane is always lane[1].
  always_comb begin
    req_mis   = (size == 2'b10 && addr[0]) || (size == 2'b11 && addr[1:0] != 2'b00);
    lane      = BIG_ENDIAN ? ~lane_q : lane_q;
    bsh       = {lane, 3'b000};
    hsh       = {lane[1], 4'b0000};
    rbyte     = 8'(mem_rdata >> bsh);
    rhalf     = 16'(mem_rdata >> hsh);
    case (size_q)
      2'b01:   load_val = {{24{~uns_q & rbyte[7]}}, rbyte};
      2'b10:   load_val = {{16{~uns_q & rhalf[15]}}, rhalf};
      default: load_val = mem_rdata;
    endcase
    if (size_q == 2'b01)
      merge_val = (mem_rdata & ~(32'h0000_00FF << bsh)) | ({24'd0, wlo_q[7:0]} << bsh);
    else
      merge_val = (mem_rdata & ~(32'h0000_FFFF << hsh)) | ({16'd0, wlo_q} << hsh);
  end

  // Next-state and registered-output logic for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wlo_d       = wlo_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          store_d    = is_store;
          size_d     = size;
          uns_d      = is_unsigned;
          lane_d     = addr[1:0];
          wlo_d      = wdata[15:0];
          mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
          cnt_d      = '0;
          if (size == 2'b00 || req_mis) begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = req_mis;
          end else if (is_store && size == 2'b11) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = wdata;
          end else begin
            state_d  = RD_WAIT;
            mem_rd_d = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CW'(MEM_LAT)) begin
          if (store_q) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = merge_val;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            rdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      wlo_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wlo_q       <= wlo_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: two instances (little-endian/latency 1 and
// big-endian/latency 3) against a byte-addressed reference model.
module tb_ls_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst[2];
  logic        start[2], is_store[2], is_unsigned[2];
  logic [1:0]  size[2];
  logic [31:0] addr[2], wdata[2], rdata[2], mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic        busy[2], done[2], misalign[2], mem_rd[2], mem_wr[2];

  logic [31:0] mem[2][64];
  logic [31:0] exp_rdata[2];
  int          vec = 0;
  int          bad = 0;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [3:0] rdp;
    // Read data is only valid MEM_LAT cycles after the read strobe cycle.
    always_ff @(posedge clock or negedge rst[g])
      if (!rst[g]) rdp <= '0;
      else         rdp <= {rdp[2:0], mem_rd[g]};
    assign mem_rdata[g] = rdp[(g == 0) ? 0 : 2] ? mem[g][mem_addr[g][7:2]] : 32'hA5A5_5A5A;

    ls_unit #(.ADDR_W(32), .MEM_LAT((g == 0) ? 1 : 3), .BIG_ENDIAN(g == 1)) dut (
      .clock(clock), .reset(rst[g]), .start(start[g]), .is_store(is_store[g]),
      .size(size[g]), .is_unsigned(is_unsigned[g]), .addr(addr[g]), .wdata(wdata[g]),
      .rdata(rdata[g]), .busy(busy[g]), .done(done[g]), .misalign(misalign[g]),
      .mem_addr(mem_addr[g]), .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory bytes in address order for a word, per endianness.
  function automatic logic [7:0] mb(input logic [31:0] w, input int k, input bit be);
    return be ? w[31-8*k -: 8] : w[8*k +: 8];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] sz, input bit un, input bit be);
    int n = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      if (be) v = (v << 8) | 32'(mb(w, int'(off) + i, be));
      else    v = v | (32'(mb(w, int'(off) + i, be)) << (8 * i));
    end
    if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic [31:0] d, input bit be);
    logic [7:0] m[4];
    int n = (sz == 2'b01) ? 1 : 2;
    for (int k = 0; k < 4; k++) m[k] = mb(w, k, be);
    for (int i = 0; i < n; i++)
      m[int'(off) + i] = be ? 8'(d >> (8 * (n - 1 - i))) : 8'(d >> (8 * i));
    return be ? {m[0], m[1], m[2], m[3]} : {m[3], m[2], m[1], m[0]};
  endfunction

  task automatic run(input int g, input bit st, input logic [1:0] sz, input bit un,
                     input logic [31:0] a, input logic [31:0] wd, input bit poke);
    int          lat  = (g == 0) ? 1 : 3;
    int          idx  = int'(a[7:2]);
    bit          be   = (g == 1);
    bit          mis  = (sz == 2'b10 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
    bit          rej  = mis || (sz == 2'b00);
    logic [31:0] word = mem[g][idx];
    logic [31:0] nword = word;
    int          e_rd = -1, e_wr = -1, e_done = 0;
    int          g_rd = -1, g_wr = -1, g_done = -1, n_rd = 0, n_wr = 0;
    logic        g_mis = 1'b0;
    if (rej) e_done = 0;
    else if (st && sz == 2'b11) begin e_wr = 0; e_done = 1; nword = wd; end
    else if (st) begin
      e_rd = 0; e_wr = lat + 1; e_done = lat + 2;
      nword = m_store(word, a[1:0], sz, wd, be);
    end else begin
      e_rd = 0; e_done = lat + 1;
      exp_rdata[g] = m_load(word, a[1:0], sz, un, be);
    end
    @(negedge clock);
    start[g] = 1'b1; is_store[g] = st; size[g] = sz; is_unsigned[g] = un;
    addr[g] = a; wdata[g] = wd;
    @(posedge clock); #1;
    start[g] = 1'b0;
    if (poke) begin
      start[g] = 1'b1; addr[g] = a ^ 32'h4; size[g] = 2'b01; is_store[g] = 1'b0;
    end
    for (int k = 0; k < 24 && g_done < 0; k++) begin
      if (k == 0) chk("busy_first", 32'(busy[g]), 32'd1);
      if (k == 1) start[g] = 1'b0;
      if (mem_rd[g]) begin
        n_rd++; g_rd = k;
        chk("rd_addr", mem_addr[g], {a[31:2], 2'b00});
      end
      if (mem_wr[g]) begin
        n_wr++; g_wr = k;
        chk("wr_addr", mem_addr[g], {a[31:2], 2'b00});
        chk("wr_data", mem_wdata[g], nword);
        mem[g][idx] = mem_wdata[g];
      end
      if (done[g]) begin
        g_done = k; g_mis = misalign[g];
      end else begin
        @(posedge clock); #1;
      end
    end
    start[g] = 1'b0;
    chk("done_cycle", g_done, e_done);
    chk("rd_cycle", g_rd, e_rd);
    chk("rd_count", n_rd, (e_rd >= 0) ? 1 : 0);
    chk("wr_cycle", g_wr, e_wr);
    chk("wr_count", n_wr, (e_wr >= 0) ? 1 : 0);
    chk("misalign", 32'(g_mis), 32'(mis));
    chk("rdata", rdata[g], exp_rdata[g]);
    @(posedge clock); #1;
    chk("idle_after", {28'd0, busy[g], done[g], mem_rd[g], mem_wr[g]}, 32'd0);
  endtask

  task automatic chk_zero(input string tag, input int g);
    chk({tag, "_ctl"}, {27'd0, busy[g], done[g], misalign[g], mem_rd[g], mem_wr[g]}, 32'd0);
    chk({tag, "_rdata"}, rdata[g], 32'd0);
    chk({tag, "_maddr"}, mem_addr[g], 32'd0);
    chk({tag, "_mwdata"}, mem_wdata[g], 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rsz;
    bit         rst_op;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0; start[g] = 1'b0; is_store[g] = 1'b0; is_unsigned[g] = 1'b0;
      size[g] = '0; addr[g] = '0; wdata[g] = '0; exp_rdata[g] = '0;
      for (int i = 0; i < 64; i++) mem[g][i] = $urandom;
    end
    #12;
    chk_zero("reset0", 0);
    chk_zero("reset1", 1);
    @(negedge clock);
    rst[0] = 1'b1; rst[1] = 1'b1;

    // Directed little-endian, latency 1
    mem[0][0] = 32'h1234_80FF;
    run(0, 0, 2'b01, 0, 32'h101, 32'h0, 0);
    chk("plan_lb", rdata[0], 32'hFFFF_FF80);
    run(0, 0, 2'b10, 1, 32'h102, 32'h0, 0);
    chk("plan_lhu", rdata[0], 32'h0000_1234);
    run(0, 0, 2'b10, 0, 32'h100, 32'h0, 0);
    chk("plan_lh", rdata[0], 32'hFFFF_80FF);
    mem[0][0] = 32'h1122_3344;
    run(0, 1, 2'b01, 0, 32'h103, 32'hAAAA_AA5C, 0);
    chk("plan_sb", mem[0][0], 32'h5C22_3344);
    run(0, 0, 2'b00, 0, 32'h100, 32'h0, 0);

    // Directed big-endian, latency 3
    mem[1][0] = 32'h7F00_0000;
    run(1, 0, 2'b01, 0, 32'h100, 32'h0, 0);
    chk("plan_be_lb", rdata[1], 32'h0000_007F);
    run(1, 0, 2'b11, 0, 32'h102, 32'h0, 0);
    chk("plan_rej_rdata", rdata[1], 32'h0000_007F);
    run(1, 1, 2'b11, 0, 32'h104, 32'hCAFE_F00D, 1);
    run(1, 1, 2'b10, 0, 32'h10A, 32'h1234_BEEF, 1);

    // Randomized traffic on both instances
    for (int i = 0; i < 120; i++) begin
      rsz = 2'($urandom_range(0, 3));
      run(i % 2, 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
          32'h100 | ($urandom & 32'hFF), $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset during a big-endian sub-word store, after a nonzero load
    mem[1][3] = 32'h8000_0001;
    run(1, 0, 2'b11, 0, 32'h10C, 32'h0, 0);
    @(negedge clock);
    start[1] = 1'b1; is_store[1] = 1'b1; size[1] = 2'b01; addr[1] = 32'h109;
    wdata[1] = 32'h0000_0066;
    @(posedge clock); #1;
    start[1] = 1'b0;
    @(posedge clock); #1;
    rst[1] = 1'b0;
    #1;
    chk_zero("midrst", 1);
    exp_rdata[1] = '0;
    rst_op = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      rst_op = rst_op | mem_wr[1] | mem_rd[1];
    end
    chk("midrst_strobes", 32'(rst_op), 32'd0);
    @(negedge clock);
    rst[1] = 1'b1;
    run(1, 0, 2'b10, 0, 32'h108, 32'h0, 0);
    run(1, 1, 2'b01, 0, 32'h109, 32'h0000_0077, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/ls_unit.md
# ls_unit

Parametrised load/store unit sitting between the multicycle datapath and word-organised data memory. It executes byte, halfword and word loads and stores at arbitrary byte addresses. Loads are lane-selected and sign- or zero-extended. Sub-word stores use a read-modify-write sequence. The block supports configurable memory read latency and endianness, and flags misaligned accesses instead of issuing them.

## Interface
- ADDR_W, 32, byte-address width (≥3)
- MEM_LAT, 1, memory read latency in cycles (≥1)
- BIG_ENDIAN, 0, 0 = byte 0 in bits [7:0], 1 = byte 0 in bits [31:24]
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 no-op, 01 byte, 10 halfword, 11 word
- is_unsigned  in  1  loads only: zero-extend instead of sign-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified
- rdata  out  32  last load result, extended
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- misalign  out  1  pulses with done when the request was rejected
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_rd  out  1  one-cycle read strobe
- mem_wr  out  1  one-cycle write strobe
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid MEM_LAT cycles after the mem_rd cycle

## Operation
- All outputs are registered. On reset (asynchronous), every output goes to 0 and the FSM goes to IDLE.
- FSM states: IDLE, RD_WAIT, WRITE, DONE.
- At the start edge, in IDLE, latch is_store, size, is_unsigned, addr and wdata. Also load mem_addr. mem_addr then holds until the next accepted start.
- Misaligned requests:
  - A request is misaligned if size=10 with addr[0]=1, or size=11 with addr[1:0]≠0.
  - Misaligned or no-op: go IDLE→DONE. No memory strobe. misalign=1 for misaligned requests only.
- Loads, and stores with size 01/10: go IDLE→RD_WAIT with mem_rd=1 for the first cycle only.
  - RD_WAIT counts MEM_LAT cycles, then captures mem_rdata.
  - A load then goes to DONE.
  - A sub-word store then goes to WRITE.
- Word store: go IDLE→WRITE directly. mem_wdata=wdata.
- WRITE: mem_wr=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. busy stays high in DONE.
- Lane select:
  - Byte lane is b=addr[1:0]. Half lane is h=addr[1].
  - If BIG_ENDIAN, use b'=3−b and h'=1−h.
  - Byte data is bits [8b+7:8b]. Half data is bits [16h+15:16h].
- Load result:
  - The selected lane is extended to 32 bits, with sign from the lane MSB unless is_unsigned.
  - is_unsigned is ignored for word loads.
  - rdata changes only at the load DONE entry. Stores, no-ops and rejections leave rdata unchanged.
- Store merge:
  - mem_wdata = captured mem_rdata with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Upper wdata bits are ignored.
- start is ignored while busy. Requests are never queued.

## Timing
- E0 is the edge that accepts start. Ek is the k-th edge after E0. L=MEM_LAT.
- Load: mem_rd high E0–E1. mem_rdata is captured at E(L+1). rdata is updated and done is high E(L+1)–E(L+2). Next start is accepted at E(L+2).
- Sub-word store: mem_rd high E0–E1. Capture at E(L+1). mem_wr high E(L+1)–E(L+2). done high E(L+2)–E(L+3).
- Word store: mem_wr high E0–E1. done high E1–E2.
- No-op or misaligned: done (and misalign) high E0–E1. No strobes.
- Reset asserted mid-operation:
  - The FSM aborts immediately and drops strobes the same instant.
  - A pending mem_rdata is discarded, and no write is issued.
  - rdata returns to 0.
- mem_addr and mem_wdata are stable throughout their strobe cycles.

## Test plan
- BIG_ENDIAN=0, MEM_LAT=1. mem word 0x1234_80FF at 0x100. Load byte at addr 0x101, signed → mem_rd at E0, rdata=0xFFFF_FF80 with done at E2.
- Same word, load half unsigned at addr 0x102 → rdata=0x0000_1234. Then load half signed at 0x100 → rdata=0xFFFF_80FF.
- Store byte wdata=0xAAAA_AA5C at addr 0x103, mem word 0x1122_3344 → mem_wr with mem_wdata=0x5C22_3344 and mem_addr=0x100. done one cycle later.
- BIG_ENDIAN=1, MEM_LAT=3. Load byte at addr 0x100 from word 0x7F00_0000 → rdata=0x0000_007F, done at E4.
- Load word at addr 0x102 → done and misalign at E0–E1. No mem_rd. rdata unchanged. A start pulse during a busy store → ignored, with no extra strobes.
- Assert reset at E1 of a MEM_LAT=3 sub-word store → all outputs 0 at once. No mem_wr. The next start after deassertion is accepted normally.
